// File: rtl/cfg_membank_loader.sv
// Row-by-row configuration loader: gathers bitstream words onto the bit lines, then pulses one word line per row.
// Define CFG_LOADER_CRC_EN to add a CRC-16-CCITT trailer check (CHECK state, cfg_error); DATA_W must then be >= 16.
module cfg_membank_loader #(
  parameter int BL_WIDTH = 514,
  parameter int WL_WIDTH = 407,
  parameter int DATA_W   = 32,
  parameter int WL_PULSE = 2
) (
  input  logic                clk,
  input  logic                global_resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [0:BL_WIDTH-1] bl_config_region_0,
  output logic [0:WL_WIDTH-1] wl_config_region_0,
  output logic                busy,
  output logic                cfg_done,
  output logic                cfg_error
);

  localparam int NW    = (BL_WIDTH + DATA_W - 1) / DATA_W;
  localparam int WC_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int ROW_W = $clog2(WL_WIDTH + 1);
  localparam int PC_W  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

`ifdef CFG_LOADER_CRC_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_HOLD, S_CHECK, S_DONE} state_e;

  // CRC-16-CCITT, MSB of the word first.
  function automatic logic [15:0] crc_word(input logic [15:0] crc_in, input logic [DATA_W-1:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[b]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_HOLD, S_DONE} state_e;
`endif

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [PC_W-1:0]     pcnt_q, pcnt_d;
  logic [0:BL_WIDTH-1] bl_q, bl_d;
  logic [0:WL_WIDTH-1] wl_q, wl_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;
`ifdef CFG_LOADER_CRC_EN
  logic [15:0]         crc_q, crc_d;
  logic                error_q, error_d;
`endif

  // s_ready_q is high exactly in the word-accepting states, so it gates the handshake directly.
  assign xfer = s_valid & s_ready_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches);
    // blocking assignments are correct here because this block is pure combinational next-state logic.
    state_d = state_q;
    row_d   = row_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    bl_d    = bl_q;
    wl_d    = wl_q;
`ifdef CFG_LOADER_CRC_EN
    crc_d   = crc_q;
    error_d = error_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          wcnt_d  = '0;
`ifdef CFG_LOADER_CRC_EN
          crc_d   = 16'hFFFF;
          error_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (xfer) begin
          // Word k lands on bit lines k*DATA_W ..; bits past BL_WIDTH simply have no destination.
          for (int j = 0; j < BL_WIDTH; j++) begin
            if (WC_W'(j / DATA_W) == wcnt_q) bl_d[j] = s_data[j % DATA_W];
          end
`ifdef CFG_LOADER_CRC_EN
          crc_d = crc_word(crc_q, s_data);
`endif
          if (wcnt_q == WC_W'(NW - 1)) begin
            state_d = S_STROBE;
            wcnt_d  = '0;
            pcnt_d  = '0;
            for (int j = 0; j < WL_WIDTH; j++) wl_d[j] = (ROW_W'(j) == row_q);
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_STROBE: begin
        if (pcnt_q == PC_W'(WL_PULSE - 1)) begin
          state_d = S_HOLD;
          wl_d    = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        row_d = row_q + 1'b1;
        if (row_q == ROW_W'(WL_WIDTH - 1)) begin
`ifdef CFG_LOADER_CRC_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef CFG_LOADER_CRC_EN
      S_CHECK: begin
        if (xfer) begin
          error_d = (s_data[15:0] != crc_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Abort outranks start and any same-cycle transfer; the word in flight is dropped.
    if (abort) begin
      state_d = S_IDLE;
      wl_d    = '0;
      bl_d    = '0;
    end

    s_ready_d = (state_d == S_LOAD);
`ifdef CFG_LOADER_CRC_EN
    s_ready_d = s_ready_d | (state_d == S_CHECK);
`endif
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      bl_q      <= '0;
      wl_q      <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
      crc_q     <= 16'hFFFF;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      bl_q      <= bl_d;
      wl_q      <= wl_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CFG_LOADER_CRC_EN
      crc_q     <= crc_d;
      error_q   <= error_d;
`endif
    end
  end

  assign s_ready            = s_ready_q;
  assign bl_config_region_0 = bl_q;
  assign wl_config_region_0 = wl_q;
  assign busy               = busy_q;
  assign cfg_done           = done_q;
`ifdef CFG_LOADER_CRC_EN
  assign cfg_error          = error_q;
`else
  assign cfg_error          = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_membank_loader.sv
// Bench for cfg_membank_loader: a 64x3 and a 40x3 loader driven in lockstep, checked against a row timeline model.
`timescale 1ns/1ps
module tb_cfg_membank_loader;

  localparam int ROWS = 3;
`ifdef CFG_LOADER_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        global_resetn;
  logic        start, abort, s_valid;
  logic [31:0] s_data;

  logic        s_ready_a, busy_a, done_a, err_a;
  logic [0:63] bl_a;
  logic [0:2]  wl_a;
  logic        s_ready_b, busy_b, done_b, err_b;
  logic [0:39] bl_b;
  logic [0:2]  wl_b;

  logic [31:0] words [6];
  logic [31:0] trailer;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cfg_membank_loader #(.BL_WIDTH(64), .WL_WIDTH(3), .DATA_W(32), .WL_PULSE(2)) dut_a (
    .clk(clk), .global_resetn(global_resetn), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
    .bl_config_region_0(bl_a), .wl_config_region_0(wl_a),
    .busy(busy_a), .cfg_done(done_a), .cfg_error(err_a)
  );

  cfg_membank_loader #(.BL_WIDTH(40), .WL_WIDTH(3), .DATA_W(32), .WL_PULSE(2)) dut_b (
    .clk(clk), .global_resetn(global_resetn), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
    .bl_config_region_0(bl_b), .wl_config_region_0(wl_b),
    .busy(busy_b), .cfg_done(done_b), .cfg_error(err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference CRC-16-CCITT over the six data words of the current pass, bit by bit MSB first.
  function automatic logic [15:0] crc_ref();
    int c;
    c = 'hFFFF;
    for (int w = 0; w < 6; w++) begin
      for (int b = 31; b >= 0; b--) begin
        int fb;
        fb = ((c >> 15) & 1) ^ int'(words[w][b]);
        c  = ((c << 1) & 'hFFFF) ^ (fb != 0 ? 'h1021 : 0);
      end
    end
    return 16'(c);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_wl_a"},    64'(wl_a),      64'(0));
    check({tag, "_bl_a"},    64'(bl_a),      64'(0));
    check({tag, "_busy_a"},  64'(busy_a),    64'(0));
    check({tag, "_ready_a"}, 64'(s_ready_a), 64'(0));
    check({tag, "_done_a"},  64'(done_a),    64'(0));
    check({tag, "_err_a"},   64'(err_a),     64'(0));
    check({tag, "_wl_b"},    64'(wl_b),      64'(0));
    check({tag, "_bl_b"},    64'(bl_b),      64'(0));
    check({tag, "_busy_b"},  64'(busy_b),    64'(0));
  endtask

  // mode 0: valid held high, 1: valid toggles, 2: random valid plus stray starts, 3: like 0 with word1 = all ones.
  task automatic run_pass(input int mode, input bit do_abort, input bit bad_crc);
    int          widx, srow, s;
    bit          finished, trailer_acc, tail;
    bit          exp_ready, exp_busy, exp_done, exp_err;
    logic [63:0] row64;
    logic [0:63] e_bl_a;
    logic [0:39] e_bl_b;
    logic [0:2]  e_wl;
    for (int i = 0; i < 6; i++) words[i] = $urandom();
    if (mode == 3) begin
      words[0] = 32'h0;
      words[1] = 32'hFFFF_FFFF;
    end
    trailer = {16'($urandom()), crc_ref() ^ {15'b0, bad_crc}};
    @(negedge clk);
    start = 1'b1; abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    widx = 0; srow = -1; s = -100; finished = 0; trailer_acc = 0;
    for (int m = 0; m < 400; m++) begin
      // Timeline: row r's last word accepted -> wl[r] on for 2 samples, one HOLD sample, then next phase.
      tail = (srow == ROWS - 1) && (m > s + 2);
      e_wl = '0; exp_ready = 0; exp_busy = 1; exp_done = 0; exp_err = 0;
      if (srow >= 0 && m >= s && m <= s + 2) begin
        if (m <= s + 1) e_wl[srow] = 1'b1;
        row64 = {words[2*srow+1], words[2*srow]};
        for (int j = 0; j < 64; j++) e_bl_a[j] = row64[j];
        for (int j = 0; j < 40; j++) e_bl_b[j] = row64[j];
        check("bl_a", 64'(bl_a), 64'(e_bl_a));
        check("bl_b", 64'(bl_b), 64'(e_bl_b));
      end else if (tail) begin
        if (CRC_EN && !trailer_acc) begin
          exp_ready = 1;
        end else begin
          exp_busy = 0; exp_done = 1; exp_err = CRC_EN && bad_crc;
        end
      end else begin
        exp_ready = 1;
      end
      check("wl_a",    64'(wl_a),      64'(e_wl));
      check("wl_b",    64'(wl_b),      64'(e_wl));
      check("ready_a", 64'(s_ready_a), 64'(exp_ready));
      check("ready_b", 64'(s_ready_b), 64'(exp_ready));
      check("busy_a",  64'(busy_a),    64'(exp_busy));
      check("busy_b",  64'(busy_b),    64'(exp_busy));
      check("done_a",  64'(done_a),    64'(exp_done));
      check("done_b",  64'(done_b),    64'(exp_done));
      check("err_a",   64'(err_a),     64'(exp_err));
      check("err_b",   64'(err_b),     64'(exp_err));
      if (exp_done) begin
        finished = 1;
        break;
      end
      if (do_abort && srow == 0 && m == s) begin
        abort = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; s_valid = 1'b0;
        check_quiet("abort");
        return;
      end
      case (mode)
        1:       s_valid = m[0];
        2:       s_valid = 1'($urandom_range(0, 1));
        default: s_valid = 1'b1;
      endcase
      s_data = !s_valid ? $urandom() : (tail ? trailer : words[widx < 6 ? widx : 5]);
      start  = (mode == 2) && ($urandom_range(0, 5) == 0);
      if (s_ready_a && s_valid) begin
        if (tail) begin
          trailer_acc = 1;
        end else begin
          widx++;
          if (widx % 2 == 0) begin
            srow = widx / 2 - 1;
            s    = m + 1;
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0; s_valid = 1'b0;
    check("pass_complete", 64'(finished), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    global_resetn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    #12;
    check_quiet("reset");
    @(negedge clk);
    global_resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("post_reset");

    run_pass(0, 1'b0, 1'b0);
    run_pass(1, 1'b0, 1'b0);
    run_pass(3, 1'b0, 1'b0);
    run_pass(2, 1'b0, 1'b0);
    run_pass(2, 1'b0, 1'b0);
    run_pass(0, 1'b1, 1'b0);
    run_pass(0, 1'b0, 1'b0);
`ifdef CFG_LOADER_CRC_EN
    run_pass(2, 1'b0, 1'b1);
    run_pass(0, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of loading a row.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = $urandom() | 32'h1;
    @(negedge clk);
    s_valid = 1'b0;
    #2 global_resetn = 1'b0;
    #1 check_quiet("reset_midload");
    @(negedge clk);
    global_resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("after_midload_reset");

    run_pass(2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_membank_loader.md
CFG_MEMBANK_LOADER -- requirements
Module: cfg_membank_loader

Interface
REQ-001 Parameter BL_WIDTH, default 514: bit-line count of the configuration region.
REQ-002 Parameter WL_WIDTH, default 407: word-line (row) count of the configuration region.
REQ-003 Parameter DATA_W, default 32: bitstream word width.
REQ-004 Parameter WL_PULSE, default 2: word-line assertion length in clock cycles, minimum 1.
REQ-005 Port clk, input, 1: sole clock, all logic rising-edge.
REQ-006 Port global_resetn, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: single-cycle request to begin a configuration pass.
REQ-008 Port abort, input, 1: cancel the pass in progress.
REQ-009 Port s_data, input, DATA_W: bitstream word.
REQ-010 Port s_valid, input, 1: s_data valid.
REQ-011 Port s_ready, output, 1: loader accepts the word.
REQ-012 Port bl_config_region_0, output, [0:BL_WIDTH-1]: bit-line drive.
REQ-013 Port wl_config_region_0, output, [0:WL_WIDTH-1]: word-line drive, at most one bit high.
REQ-014 Port busy, output, 1: pass in progress.
REQ-015 Port cfg_done, output, 1: pass completed, level.
REQ-016 Port cfg_error, output, 1: bitstream check failed, level.

Function
REQ-017 States IDLE, LOAD, STROBE, HOLD, CHECK and DONE; CHECK exists only per REQ-035.
REQ-018 IDLE: start=1 -> LOAD on the next edge, with row=0 and word count=0, clearing cfg_done and cfg_error.
REQ-019 DONE: start=1 -> LOAD with the same clearing; otherwise DONE holds.
REQ-020 s_ready = 1 only in LOAD (or CHECK); a word transfers on s_valid & s_ready at a rising edge.
REQ-021 Each row takes NW = ceil(BL_WIDTH/DATA_W) words; word k bit i -> bl_config_region_0[k*DATA_W+i]; bits at index >= BL_WIDTH are discarded.
REQ-022 The NW-th transfer of a row -> STROBE on the next edge; bl_config_region_0 is stable from then until the row's HOLD ends.
REQ-023 STROBE: wl_config_region_0[row]=1 for exactly WL_PULSE cycles, then -> HOLD.
REQ-024 HOLD: one cycle, all word lines 0, bit lines unchanged; then row increments.
REQ-025 After HOLD: row==WL_WIDTH -> DONE (or CHECK); otherwise -> LOAD.
REQ-026 busy=1 in LOAD, STROBE, HOLD and CHECK; cfg_done=1 only in DONE.
REQ-027 abort=1 in any state -> IDLE on the next edge; word lines drop immediately on that edge, bit lines clear to 0, cfg_done=0.
REQ-028 abort has priority over start and over a concurrent transfer; that word is dropped.
REQ-029 start while busy is ignored.
REQ-030 s_valid stalls in LOAD hold state indefinitely; no timeout.

Reset
REQ-031 global_resetn=0 asynchronously forces IDLE, row=0 and word count=0.
REQ-032 During reset all outputs read 0: s_ready, busy, cfg_done, cfg_error, all bit lines and all word lines.
REQ-033 Release is synchronous to clk: the first edge after deassertion evaluates IDLE.
REQ-034 Reset mid-strobe drops the word line without waiting for WL_PULSE.

Configuration
REQ-035 With CFG_LOADER_CRC_EN defined:
- CRC-16-CCITT (poly 0x1021, init 0xFFFF) runs over every accepted data word, MSB first.
- After the last row's HOLD, the loader enters CHECK and accepts one trailer word.
- Trailer bits [15:0] not equal to the CRC -> cfg_error=1.
- Then -> DONE.
REQ-036 Without CFG_LOADER_CRC_EN: no CHECK state, no CRC logic, and cfg_error is tied to 0.

Verification
REQ-037 BL_WIDTH=64, WL_WIDTH=3, DATA_W=32. Stimulus: start, then 6 words with s_valid held high. Required:
- Each row gets a 2-cycle one-hot word-line pulse, wl[0], then wl[1], then wl[2].
- Bit lines equal {word1,word0} of that row during each pulse.
- cfg_done rises once, after the third HOLD.
REQ-038 BL_WIDTH=40, DATA_W=32, second word 0xFFFFFFFF. Required: bl[32:39]=0xFF and no other bits are affected.
REQ-039 Toggle s_valid every other cycle during a pass. Required: word-line timing per row is unchanged and no word is lost or duplicated.
REQ-040 Assert abort in STROBE cycle 1. Required: next cycle wl=0, bl=0, busy=0, and state IDLE; a fresh start completes normally.
REQ-041 Assert global_resetn=0 asynchronously mid-LOAD. Required: all outputs are 0 before the next clk edge.
REQ-042 With CFG_LOADER_CRC_EN defined:
- Correct trailer -> cfg_done=1, cfg_error=0.
- Trailer with bit 0 flipped -> cfg_done=1, cfg_error=1.
